// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle core.
// Holds the opcode and FSM state encodings, the instruction layout for the
// default 8-bit / 4-register configuration, and helper functions that derive
// the register-index width and the instruction width from the core parameters.
package cpu_types_pkg;

  localparam int OPCODE_W       = 4;
  localparam int PKG_DATA_WIDTH = 8;
  localparam int PKG_REG_COUNT  = 4;

  // Width of a register index; a single-register file still needs one bit.
  function automatic int reg_bits(input int reg_count);
    return (reg_count < 2) ? 1 : $clog2(reg_count);
  endfunction

  // Instruction word = opcode + dst index + src index + immediate.
  function automatic int instr_width(input int data_width, input int reg_count);
    return OPCODE_W + 2 * reg_bits(reg_count) + data_width;
  endfunction

  localparam int PKG_RB = reg_bits(PKG_REG_COUNT);

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALTED
  } state_e;

  // Field layout, MSB first, for the default configuration.
  typedef struct packed {
    opcode_e                   opcode;
    logic [PKG_RB-1:0]         dst;
    logic [PKG_RB-1:0]         src;
    logic [PKG_DATA_WIDTH-1:0] imm;
  } instr_t;

endpackage

// File: rtl/multicycle_datapath_if.sv
// Memory-side bus of the multicycle core: one instruction fetch port and one
// data port, each using a req/ack handshake.
//   master : the core (drives req/addr/we/wdata, receives ack/rdata)
//   slave  : the memory models (drive ack/rdata)
interface multicycle_datapath_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int INSTR_W    = 16
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [INSTR_W-1:0]    imem_rdata;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mc_reg_file.sv
// General register file for the multicycle core.
// REG_COUNT x DATA_WIDTH, two combinational read ports, one synchronous write
// port, synchronous active-high reset clearing every register.
//   clk, reset            : clock and synchronous reset
//   rd_addr_a / rd_data_a : read port A
//   rd_addr_b / rd_data_b : read port B
//   wr_en, wr_addr, wr_data : write port, applied on the rising edge
module mc_reg_file
  import cpu_types_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  REG_COUNT  = 4,
  localparam int RB         = reg_bits(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RB-1:0]         rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [RB-1:0]         rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [RB-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];

  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle CPU core: datapath plus control FSM, one instruction at a time
// through FETCH / DECODE / EXECUTE / MEM / WRITEBACK.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : master side of multicycle_datapath_if (imem and dmem req/ack ports)
//   zero       : registered zero flag from the last ADD/SUB/AND/OR
//   halted     : core is in HALTED (left only through reset)
//   pc         : current program counter (also the fetch address)
// Optional build macro MULTICYCLE_DATAPATH_RETIRE_EN adds retire_valid /
// retire_pc, a one-cycle pulse with the address of each completed instruction.
module multicycle_datapath
  import cpu_types_pkg::*;
#(
  parameter int  DATA_WIDTH = 8,
  parameter int  ADDR_WIDTH = 8,
  parameter int  REG_COUNT  = 4,
  localparam int RB         = reg_bits(REG_COUNT),
  localparam int INSTR_W    = instr_width(DATA_WIDTH, REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_datapath_if.master bus,
  output logic                  zero,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc
`ifdef MULTICYCLE_DATAPATH_RETIRE_EN
  ,
  output logic                  retire_valid,
  output logic [ADDR_WIDTH-1:0] retire_pc
`endif
);

  // Wide enough to zero-extend or truncate a data value into an address.
  localparam int EXT_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [DATA_WIDTH-1:0] rs_q, rs_d, rd_q, rd_d, result_q, result_d;
  logic                  zero_q, zero_d, halted_q, halted_d;
  logic                  imem_req_q, imem_req_d;
  logic                  dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;

  opcode_e               opcode;
  logic [RB-1:0]         dst, src;
  logic [DATA_WIDTH-1:0] imm, alu_out, rf_rs, rf_rd, rf_wr_data;
  logic [EXT_W-1:0]      imm_ext, rs_ext;
  logic                  is_alu;

  assign opcode  = opcode_e'(ir_q[INSTR_W-1 -: OPCODE_W]);
  assign dst     = ir_q[INSTR_W-OPCODE_W-1 -: RB];
  assign src     = ir_q[DATA_WIDTH+RB-1 -: RB];
  assign imm     = ir_q[DATA_WIDTH-1:0];
  assign imm_ext = EXT_W'(imm);
  assign rs_ext  = EXT_W'(rs_q);
  assign is_alu  = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};

  // Only LDI, ALU ops and LD ever reach WRITEBACK, so the state alone is the write enable.
  assign rf_wr_data = (opcode == OP_LDI) ? imm : result_q;

  mc_reg_file #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (src),
    .rd_data_a (rf_rs),
    .rd_addr_b (dst),
    .rd_data_b (rf_rd),
    .wr_en     (state_q == S_WRITEBACK),
    .wr_addr   (dst),
    .wr_data   (rf_wr_data)
  );

  // ALU on the latched operands; SUB is rd - rs, all arithmetic wraps.
  always_comb begin
    alu_out = '0;
    case (opcode)
      OP_ADD:  alu_out = rd_q + rs_q;
      OP_SUB:  alu_out = rd_q - rs_q;
      OP_AND:  alu_out = rd_q & rs_q;
      OP_OR:   alu_out = rd_q | rs_q;
      default: alu_out = '0;
    endcase
  end

  // Next-state logic. Request lines are registered and raised on the edge that
  // enters FETCH or MEM, so memory sees req from the first cycle of the state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    rs_d         = rs_q;
    rd_d         = rd_q;
    result_d     = result_q;
    zero_d       = zero_q;
    halted_d     = halted_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;

    case (state_q)
      S_FETCH: begin
        // req is only low here on the first cycle after reset
        if (!imem_req_q) begin
          imem_req_d = 1'b1;
        end else if (bus.imem_ack) begin
          ir_d       = bus.imem_rdata;
          pc_d       = pc_q + ADDR_WIDTH'(1);
          imem_req_d = 1'b0;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        rs_d    = rf_rs;
        rd_d    = rf_rd;
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_alu) begin
          result_d = alu_out;
          zero_d   = (alu_out == '0);
          state_d  = S_WRITEBACK;
        end else if (opcode == OP_LDI) begin
          state_d = S_WRITEBACK;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          dmem_req_d   = 1'b1;
          dmem_we_d    = (opcode == OP_ST);
          dmem_addr_d  = rs_ext[ADDR_WIDTH-1:0];
          dmem_wdata_d = rd_q;
          state_d      = S_MEM;
        end else if (opcode == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else begin
          // JMP, JZ, NOP and undefined opcodes all return straight to fetch
          if (opcode == OP_JMP || (opcode == OP_JZ && zero_q)) begin
            pc_d = imm_ext[ADDR_WIDTH-1:0];
          end
          imem_req_d = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEM: begin
        if (dmem_req_q && bus.dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (dmem_we_q) begin
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end else begin
            result_d = bus.dmem_rdata;
            state_d  = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        imem_req_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      rs_q         <= '0;
      rd_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      halted_q     <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      rs_q         <= rs_d;
      rd_q         <= rd_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      halted_q     <= halted_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign zero           = zero_q;
  assign halted         = halted_q;
  assign pc             = pc_q;

`ifdef MULTICYCLE_DATAPATH_RETIRE_EN
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;

  // Address of the instruction currently in flight, captured at fetch.
  always_comb begin
    ipc_d = ipc_q;
    if (state_q == S_FETCH && imem_req_q && bus.imem_ack) ipc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) ipc_q <= '0;
    else       ipc_q <= ipc_d;
  end

  // Completion points: end of WRITEBACK, store ack, or an EXECUTE that leaves
  // for FETCH or HALTED.
  always_comb begin
    retire_valid = 1'b0;
    case (state_q)
      S_WRITEBACK: retire_valid = 1'b1;
      S_MEM:       retire_valid = dmem_req_q && bus.dmem_ack && dmem_we_q;
      S_EXECUTE:   retire_valid = !(is_alu || opcode inside {OP_LDI, OP_LD, OP_ST});
      default:     retire_valid = 1'b0;
    endcase
  end

  assign retire_pc = ipc_q;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: an instruction-level model of
// the ISA runs alongside the core and is compared on every handshake cycle,
// plus literal expectations for the directed program.
module tb_multicycle_datapath;
  import cpu_types_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RC = 4;
  localparam int RB = reg_bits(RC);
  localparam int IW = instr_width(DW, RC);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          zero, halted;
  logic [AW-1:0] pc;

  multicycle_datapath_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_W(IW)) bus ();

`ifdef MULTICYCLE_DATAPATH_RETIRE_EN
  logic          retire_valid;
  logic [AW-1:0] retire_pc;
`endif

  multicycle_datapath #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .REG_COUNT  (RC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .zero   (zero),
    .halted (halted),
    .pc     (pc)
`ifdef MULTICYCLE_DATAPATH_RETIRE_EN
    ,
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc)
`endif
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  // Memories and responder controls
  logic [IW-1:0] imem [256];
  logic [DW-1:0] dmem [256];
  int            imem_delay = 0;
  int            dmem_delay = 0;
  int            write_count = 0;
  bit            ghost_ack = 1'b0;

  // Scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DW-1:0] m_regs [RC];
  logic [AW-1:0] m_pc;
  bit            m_zero, m_halted;
  bit            exp_pending, exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  int            fetch_cyc [$];
  int            fetch_addr [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int idelay, input int ddelay);
    imem_delay = idelay;
    dmem_delay = ddelay;
  endtask

  function automatic logic [IW-1:0] enc(input opcode_e op, input int d, input int s, input int imm);
    return {op, RB'(d), RB'(s), DW'(imm)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < RC; i++) m_regs[i] = '0;
    m_pc        = '0;
    m_zero      = 1'b0;
    m_halted    = 1'b0;
    exp_pending = 1'b0;
    fetch_cyc.delete();
    fetch_addr.delete();
  endfunction

  // Architectural effect of one whole instruction.
  function automatic void model_step(input logic [IW-1:0] word);
    instr_t        f;
    logic [DW-1:0] a, b, r;
    f    = instr_t'(word);
    a    = m_regs[f.dst];
    b    = m_regs[f.src];
    r    = '0;
    m_pc = m_pc + 8'd1;
    case (f.opcode)
      OP_LDI: m_regs[f.dst] = f.imm;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        if (f.opcode == OP_ADD)      r = DW'(int'(a) + int'(b));
        else if (f.opcode == OP_SUB) r = DW'(int'(a) - int'(b));
        else if (f.opcode == OP_AND) r = a & b;
        else                         r = a | b;
        m_regs[f.dst] = r;
        m_zero = (r == 0);
      end
      OP_LD: begin
        exp_pending = 1'b1; exp_we = 1'b0; exp_addr = b;
        m_regs[f.dst] = dmem[b];
      end
      OP_ST: begin
        exp_pending = 1'b1; exp_we = 1'b1; exp_addr = b; exp_wdata = a;
      end
      OP_JMP:  m_pc = f.imm;
      OP_JZ:   if (m_zero) m_pc = f.imm;
      OP_HALT: m_halted = 1'b1;
      default: ;
    endcase
  endfunction

  // Instruction memory: ack after imem_delay cycles of req.
  initial begin
    int wc = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      bus.imem_ack = 1'b0;
      if (bus.imem_req && !reset) begin
        if (wc >= imem_delay) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = imem[bus.imem_addr];
          wc = 0;
        end else wc++;
      end else wc = 0;
    end
  end

  // Data memory: ack after dmem_delay cycles; ghost_ack pulses ack with no request.
  initial begin
    int wc = 0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      bus.dmem_ack = 1'b0;
      if (bus.dmem_req && !reset) begin
        if (wc >= dmem_delay) begin
          bus.dmem_ack = 1'b1;
          if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            write_count++;
          end else begin
            bus.dmem_rdata = dmem[bus.dmem_addr];
          end
          wc = 0;
        end else wc++;
      end else begin
        wc = 0;
        if (ghost_ack) bus.dmem_ack = 1'b1;
      end
    end
  end

  // Compare process: model against outputs on every meaningful cycle.
  always @(negedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      if (bus.imem_req || bus.dmem_req)
        checkOutput("one_port_at_a_time", 32'(bus.imem_req & bus.dmem_req), 32'd0);
      if (bus.imem_req) begin
        checkOutput("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        checkOutput("pc_at_fetch", 32'(pc), 32'(m_pc));
        if (bus.imem_ack) begin
          checkOutput("zero_at_fetch", 32'(zero), 32'(m_zero));
          fetch_cyc.push_back(cycle);
          fetch_addr.push_back(int'(m_pc));
          model_step(imem[m_pc]);
        end
      end
      if (bus.dmem_req) begin
        checkOutput("dmem_req_expected", 32'(exp_pending), 32'd1);
        checkOutput("dmem_addr", 32'(bus.dmem_addr), 32'(exp_addr));
        checkOutput("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
        if (exp_we) checkOutput("dmem_wdata", 32'(bus.dmem_wdata), 32'(exp_wdata));
        if (bus.dmem_ack) exp_pending = 1'b0;
      end
      if (halted) checkOutput("halted_only_after_halt", 32'(m_halted), 32'd1);
    end
  end

  task automatic waitHalted(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("halt_within_budget", 32'(halted), 32'd1);
  endtask

  task automatic applyReset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic checkFinalState(input int exp_writes);
    checkOutput("fetch_count", 32'(fetch_addr.size()), 32'd20);
    checkOutput("jz_taken_target", 32'(fetch_addr[8]), 32'h20);
    checkOutput("jz_not_taken_seq", 32'(fetch_addr[14]), 32'h26);
    checkOutput("last_fetch_halt", 32'(fetch_addr[19]), 32'h30);
    checkOutput("model_r0", 32'(m_regs[0]), 32'h10);
    checkOutput("model_r1_or", 32'(m_regs[1]), 32'hAF);
    checkOutput("model_r2_ld_and", 32'(m_regs[2]), 32'hAB);
    checkOutput("model_r3", 32'(m_regs[3]), 32'hAB);
    checkOutput("dmem0_add_wrap", 32'(dmem[0]), 32'd44);
    checkOutput("dmem10_or", 32'(dmem[8'h10]), 32'hAF);
    checkOutput("write_count", 32'(write_count), 32'(exp_writes));
    checkOutput("zero_final", 32'(zero), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("halted_no_fetch", 32'(bus.imem_req), 32'd0);
      checkOutput("halted_no_dmem", 32'(bus.dmem_req), 32'd0);
      checkOutput("halted_pc_frozen", 32'(pc), 32'h31);
      checkOutput("halted_stays", 32'(halted), 32'd1);
    end
  endtask

  initial begin
    int n;
    int saved_writes;
    for (int i = 0; i < 256; i++) begin
      imem[i] = enc(OP_HALT, 0, 0, 0);
      dmem[i] = '0;
    end
    imem[8'h00] = enc(OP_LDI, 1, 0, 5);
    imem[8'h01] = enc(OP_ST, 1, 0, 0);
    imem[8'h02] = enc(OP_LDI, 1, 0, 200);
    imem[8'h03] = enc(OP_LDI, 2, 0, 100);
    imem[8'h04] = enc(OP_ADD, 1, 2, 0);
    imem[8'h05] = enc(OP_ST, 1, 0, 0);
    imem[8'h06] = enc(OP_SUB, 2, 2, 0);
    imem[8'h07] = enc(OP_JZ, 0, 0, 8'h20);
    imem[8'h20] = enc(OP_LDI, 0, 0, 8'h10);
    imem[8'h21] = enc(OP_LDI, 3, 0, 8'hAB);
    imem[8'h22] = enc(OP_ST, 3, 0, 0);
    imem[8'h23] = enc(OP_LD, 2, 0, 0);
    imem[8'h24] = enc(OP_AND, 2, 3, 0);
    imem[8'h25] = enc(OP_JZ, 0, 0, 8'h40);
    imem[8'h26] = enc(OP_OR, 1, 2, 0);
    imem[8'h27] = enc(OP_ST, 1, 0, 0);
    imem[8'h28] = enc(OP_NOP, 0, 0, 0);
    imem[8'h29] = {4'hC, 12'h000};
    imem[8'h2A] = enc(OP_JMP, 0, 0, 8'h30);
    imem[8'h30] = enc(OP_HALT, 0, 0, 0);

    // Run 1: same-cycle fetch ack, data ack delayed 3 cycles.
    applyStimulus(0, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_pc", 32'(pc), 32'd0);
    checkOutput("reset_zero", 32'(zero), 32'd0);
    checkOutput("reset_halted", 32'(halted), 32'd0);
    checkOutput("reset_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("reset_dmem_req", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    waitHalted(400);
    checkOutput("ldi_latency", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd4);
    checkOutput("st_latency_wait3", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd7);
    checkOutput("add_latency", 32'(fetch_cyc[5] - fetch_cyc[4]), 32'd4);
    checkOutput("jz_latency", 32'(fetch_cyc[8] - fetch_cyc[7]), 32'd3);
    checkFinalState(4);

    // Run 2: reset out of HALTED, then reset again in the middle of a store wait.
    applyStimulus(0, 6);
    applyReset();
    n = 0;
    while (!bus.dmem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("store_reached_mem", 32'(bus.dmem_req), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("midmem_reset_dmem_req", 32'(bus.dmem_req), 32'd0);
    checkOutput("midmem_reset_pc", 32'(pc), 32'd0);
    checkOutput("midmem_reset_halted", 32'(halted), 32'd0);
    saved_writes = write_count;
    @(posedge clk); #1 ghost_ack = 1'b1;
    @(posedge clk); #1 ghost_ack = 1'b0;
    checkOutput("ghost_ack_no_write", 32'(write_count), 32'(saved_writes));
    applyStimulus(1, 1);

    waitHalted(600);
    checkOutput("restart_at_zero", 32'(fetch_addr[0]), 32'd0);
    checkFinalState(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
